i2c_slave_ctrl: RTL and testbench



---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_bus_sync.sv | 53 +++++
 rtl/i2c_slave_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target endpoint: FSM state encoding,
// R/W bit polarity and the byte returned when the read source runs dry.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ADDR     = 3'd1,
      ADDR_ACK = 3'd2,
      RX_BYTE  = 3'd3,
      RX_ACK   = 3'd4,
      TX_BYTE  = 3'd5,
      TX_ACK   = 3'd6,
      IGNORE   = 3'd7
   } i2c_state_t;

   localparam logic       I2C_RW_READ   = 1'b1;
   localparam logic [7:0] UNDERRUN_BYTE = 8'hFF;

   function automatic logic addr_hit(input logic [6:0] rx_addr,
                                     input logic [6:0] own);
      return rx_addr == own;
   endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser and bus event detector.
// Ports: clk, rst_n, scl_in, sda_in -> scl_rise, scl_fall, sda_s, start_evt, stop_evt.
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_rise,
   output logic scl_fall,
   output logic sda_s,
   output logic start_evt,
   output logic stop_evt
);

   logic [SYNC_STAGES-1:0] scl_sr;
   logic [SYNC_STAGES-1:0] sda_sr;
   logic                   scl_q;
   logic                   sda_q;
   logic [SYNC_STAGES:0]   arm_sr;
   logic                   scl_s;
   logic                   armed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sr <= '1;
         sda_sr <= '1;
         scl_q  <= 1'b1;
         sda_q  <= 1'b1;
         arm_sr <= '0;
      end else begin
         scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl_in};
         sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda_in};
         scl_q  <= scl_sr[SYNC_STAGES-1];
         sda_q  <= sda_sr[SYNC_STAGES-1];
         arm_sr <= {arm_sr[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign scl_s = scl_sr[SYNC_STAGES-1];
   assign sda_s = sda_sr[SYNC_STAGES-1];

   // Edges are suppressed until the pipeline holds real pin samples, so
   // the reset preset of the flops cannot fake a START after reset.
   assign armed = arm_sr[SYNC_STAGES];

   assign scl_rise  = armed & scl_s & ~scl_q;
   assign scl_fall  = armed & ~scl_s & scl_q;
   assign start_evt = armed & scl_s & scl_q & sda_q & ~sda_s;
   assign stop_evt  = armed & scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C target endpoint: 7-bit address match, write bytes to rx stream,
// read bytes from tx stream, open-drain SDA, no clock stretching.
// Ports: clk, rst_n, en, own_addr, scl_in, sda_in, sda_out, sda_oe,
//   rx_data/rx_valid/rx_ready, tx_data/tx_valid/tx_req, busy,
//   start_det, stop_det, tx_underrun.
module i2c_slave_ctrl
   import i2c_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [6:0] own_addr,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_out,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_req,
   output logic       busy,
   output logic       start_det,
   output logic       stop_det,
   output logic       tx_underrun
);

   logic scl_rise;
   logic scl_fall;
   logic sda_s;
   logic start_evt;
   logic stop_evt;

   i2c_bus_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .scl_in   (scl_in),
      .sda_in   (sda_in),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .sda_s    (sda_s),
      .start_evt(start_evt),
      .stop_evt (stop_evt)
   );

   i2c_state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] sh_q, sh_d;
   logic       rw_q, rw_d;
   logic       rx_ack_q, rx_ack_d;
   logic       m_nack_q, m_nack_d;
   logic       busy_q, busy_d;
   logic       oe_q, oe_d;
   logic [7:0] rxd_q, rxd_d;
   logic       rxv_q, rxv_d;
   logic       treq_q, treq_d;
   logic       und_q, und_d;
   logic       sdet_q, sdet_d;
   logic       pdet_q, pdet_d;
   logic [7:0] tx_byte;

   assign tx_byte = tx_valid ? tx_data : UNDERRUN_BYTE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sh_q     <= '0;
         rw_q     <= 1'b0;
         rx_ack_q <= 1'b0;
         m_nack_q <= 1'b0;
         busy_q   <= 1'b0;
         oe_q     <= 1'b0;
         rxd_q    <= '0;
         rxv_q    <= 1'b0;
         treq_q   <= 1'b0;
         und_q    <= 1'b0;
         sdet_q   <= 1'b0;
         pdet_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sh_q     <= sh_d;
         rw_q     <= rw_d;
         rx_ack_q <= rx_ack_d;
         m_nack_q <= m_nack_d;
         busy_q   <= busy_d;
         oe_q     <= oe_d;
         rxd_q    <= rxd_d;
         rxv_q    <= rxv_d;
         treq_q   <= treq_d;
         und_q    <= und_d;
         sdet_q   <= sdet_d;
         pdet_q   <= pdet_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sh_d     = sh_q;
      rw_d     = rw_q;
      rx_ack_d = rx_ack_q;
      m_nack_d = m_nack_q;
      busy_d   = busy_q;
      oe_d     = oe_q;
      rxd_d    = rxd_q;
      rxv_d    = 1'b0;
      treq_d   = 1'b0;
      und_d    = 1'b0;
      sdet_d   = 1'b0;
      pdet_d   = 1'b0;

      if (!en) begin
         state_d = IDLE;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
         cnt_d   = '0;
      end else if (start_evt) begin
         sdet_d  = 1'b1;
         cnt_d   = '0;
         state_d = ADDR;
         oe_d    = 1'b0;
      end else if (stop_evt) begin
         pdet_d  = 1'b1;
         state_d = IDLE;
         busy_d  = 1'b0;
         oe_d    = 1'b0;
      end else begin
         unique case (state_q)
            IDLE, IGNORE: begin
               oe_d = 1'b0;
            end
            ADDR: begin
               if (scl_rise && cnt_q < 4'd8) begin
                  sh_d  = {sh_q[6:0], sda_s};
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     if (addr_hit(sh_q[6:0], own_addr)) begin
                        busy_d = 1'b1;
                        rw_d   = sda_s;
                     end else begin
                        state_d = IGNORE;
                     end
                  end
               end else if (scl_fall && cnt_q == 4'd8) begin
                  state_d = ADDR_ACK;
                  oe_d    = 1'b1;
                  cnt_d   = '0;
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  if (rw_q == I2C_RW_READ) begin
                     sh_d    = {tx_byte[6:0], 1'b0};
                     oe_d    = ~tx_byte[7];
                     cnt_d   = 4'd1;
                     treq_d  = 1'b1;
                     und_d   = ~tx_valid;
                     state_d = TX_BYTE;
                  end else begin
                     oe_d    = 1'b0;
                     cnt_d   = '0;
                     state_d = RX_BYTE;
                  end
               end
            end
            RX_BYTE: begin
               if (scl_rise) begin
                  sh_d  = {sh_q[6:0], sda_s};
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     rx_ack_d = rx_ready;
                     rxv_d    = rx_ready;
                     if (rx_ready) begin
                        rxd_d = {sh_q[6:0], sda_s};
                     end
                     cnt_d   = '0;
                     state_d = RX_ACK;
                  end
               end
            end
            RX_ACK: begin
               // First fall opens the ACK slot, second fall closes it.
               if (scl_fall) begin
                  if (cnt_q == 4'd0) begin
                     oe_d  = rx_ack_q;
                     cnt_d = 4'd1;
                  end else begin
                     oe_d    = 1'b0;
                     cnt_d   = '0;
                     state_d = RX_BYTE;
                  end
               end
            end
            TX_BYTE: begin
               if (scl_fall) begin
                  if (cnt_q == 4'd8) begin
                     oe_d    = 1'b0;
                     cnt_d   = '0;
                     state_d = TX_ACK;
                  end else begin
                     oe_d  = ~sh_q[7];
                     sh_d  = {sh_q[6:0], 1'b0};
                     cnt_d = cnt_q + 4'd1;
                  end
               end
            end
            TX_ACK: begin
               if (scl_rise && cnt_q == 4'd0) begin
                  m_nack_d = sda_s;
                  cnt_d    = 4'd1;
               end else if (scl_fall && cnt_q == 4'd1) begin
                  if (!m_nack_q) begin
                     sh_d    = {tx_byte[6:0], 1'b0};
                     oe_d    = ~tx_byte[7];
                     cnt_d   = 4'd1;
                     treq_d  = 1'b1;
                     und_d   = ~tx_valid;
                     state_d = TX_BYTE;
                  end else begin
                     oe_d    = 1'b0;
                     cnt_d   = '0;
                     state_d = IGNORE;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               oe_d    = 1'b0;
            end
         endcase
      end
   end

   assign sda_out     = 1'b0;
   assign sda_oe      = oe_q;
   assign rx_data     = rxd_q;
   assign rx_valid    = rxv_q;
   assign tx_req      = treq_q;
   assign busy        = busy_q;
   assign start_det   = sdet_q;
   assign stop_det    = pdet_q;
   assign tx_underrun = und_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: behavioural bus master plus transaction-level
// reference model with randomized addresses, directions and payloads.
module tb_i2c_slave_ctrl;

   localparam int Q = 6;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1;
   logic [6:0] own_addr = 7'h50;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       scl_in;
   logic       sda_in;
   logic       sda_out;
   logic       sda_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b1;
   logic       tx_req;
   logic       busy;
   logic       start_det;
   logic       stop_det;
   logic       tx_underrun;

   assign scl_in = m_scl;
   assign sda_in = m_sda & ~sda_oe;

   i2c_slave_ctrl #(.SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .own_addr   (own_addr),
      .scl_in     (scl_in),
      .sda_in     (sda_in),
      .sda_out    (sda_out),
      .sda_oe     (sda_oe),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_req     (tx_req),
      .busy       (busy),
      .start_det  (start_det),
      .stop_det   (stop_det),
      .tx_underrun(tx_underrun)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int n_start = 0;
   int n_stop = 0;
   int n_treq = 0;
   int n_und = 0;
   int n_both = 0;
   logic [7:0] rxq[$];

   logic [7:0] w_data[4];
   logic       w_rdy[4];
   logic [7:0] t_data[4];
   logic       t_val[4];

   always @(negedge clk) begin
      if (rst_n) begin
         if (start_det) n_start++;
         if (stop_det) n_stop++;
         if (tx_req) n_treq++;
         if (tx_underrun) n_und++;
         if (rx_valid && tx_req) n_both++;
         if (rx_valid) rxq.push_back(rx_data);
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      if (!m_scl) begin
         m_sda = 1'b1;
         tick(Q);
         m_scl = 1'b1;
      end
      tick(Q);
      m_sda = 1'b0;
      tick(Q);
      m_scl = 1'b0;
      tick(Q);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0;
      tick(Q);
      m_scl = 1'b1;
      tick(Q);
      m_sda = 1'b1;
      tick(2 * Q);
   endtask

   task automatic wbit(input logic b);
      m_sda = b;
      tick(Q);
      m_scl = 1'b1;
      tick(2 * Q);
      m_scl = 1'b0;
      tick(Q);
   endtask

   task automatic rbit(output logic b);
      m_sda = 1'b1;
      tick(Q);
      m_scl = 1'b1;
      tick(Q);
      b = sda_in;
      tick(Q);
      m_scl = 1'b0;
      tick(Q);
   endtask

   task automatic wbyte(input logic [7:0] d, output logic ack);
      logic a;
      for (int i = 7; i >= 0; i--) wbit(d[i]);
      rbit(a);
      ack = ~a;
   endtask

   task automatic rbyte(output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         rbit(b);
         d[i] = b;
      end
   endtask

   // One complete transaction; expectations come from the I2C rules:
   // ACK only on address match while enabled, write bytes kept only when
   // the sink is ready, read bytes are the source data or 0xFF.
   task automatic xfer(input logic [6:0] addr, input logic rw, input int n);
      int s_st, s_sp, s_tr, s_un;
      int e_tr, e_un;
      logic ack, hit;
      logic [7:0] d, e;
      logic [7:0] expq[$];
      s_st = n_start;
      s_sp = n_stop;
      s_tr = n_treq;
      s_un = n_und;
      rxq.delete();
      hit = en && (addr == own_addr);
      e_tr = 0;
      e_un = 0;
      if (hit && rw) begin
         e_tr = n;
         for (int k = 0; k < n; k++) if (!t_val[k]) e_un++;
      end
      if (rw) begin
         tx_data = t_data[0];
         tx_valid = t_val[0];
      end
      i2c_start();
      wbyte({addr, rw}, ack);
      check("addr_ack", ack, hit);
      check("busy_on", busy, hit);
      if (ack) begin
         for (int k = 0; k < n; k++) begin
            if (!rw) begin
               rx_ready = w_rdy[k];
               wbyte(w_data[k], ack);
               check("wr_ack", ack, w_rdy[k]);
               if (w_rdy[k]) expq.push_back(w_data[k]);
               if (!ack) break;
            end else begin
               rbyte(d);
               e = t_val[k] ? t_data[k] : 8'hFF;
               check("rd_byte", d, e);
               if (k < n - 1) begin
                  tx_data = t_data[k+1];
                  tx_valid = t_val[k+1];
                  wbit(1'b0);
               end else begin
                  wbit(1'b1);
               end
            end
         end
      end
      check("sda_rel", sda_oe, 0);
      i2c_stop();
      check("start_cnt", n_start - s_st, en ? 1 : 0);
      check("stop_cnt", n_stop - s_sp, en ? 1 : 0);
      check("treq_cnt", n_treq - s_tr, e_tr);
      check("und_cnt", n_und - s_un, e_un);
      check("busy_off", busy, 0);
      check("rx_cnt", rxq.size(), expq.size());
      for (int i = 0; i < expq.size() && i < rxq.size(); i++)
         check("rx_data", rxq[i], expq[i]);
   endtask

   initial begin
      logic ack, b;
      logic [7:0] d;
      int s_st, s_sp, s_tr;

      tick(4);
      check("rst_oe", sda_oe, 0);
      check("rst_out", sda_out, 0);
      check("rst_rxd", rx_data, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      tick(10);

      own_addr = 7'h50;
      w_data[0] = 8'h3C; w_rdy[0] = 1'b1;
      xfer(7'h50, 1'b0, 1);

      w_data[0] = 8'h11;
      xfer(7'h51, 1'b0, 1);

      t_data[0] = 8'h96; t_val[0] = 1'b1;
      t_data[1] = 8'h5A; t_val[1] = 1'b1;
      xfer(7'h50, 1'b1, 2);

      t_val[0] = 1'b0;
      xfer(7'h50, 1'b1, 1);

      w_data[0] = 8'h77; w_rdy[0] = 1'b0;
      xfer(7'h50, 1'b0, 1);

      en = 1'b0;
      w_data[0] = 8'h42; w_rdy[0] = 1'b1;
      xfer(7'h50, 1'b0, 1);
      en = 1'b1;
      tick(4);

      // Repeated START four bits into a write byte.
      s_st = n_start;
      s_tr = n_treq;
      rxq.delete();
      rx_ready = 1'b1;
      i2c_start();
      wbyte(8'hA0, ack);
      check("rs_wack", ack, 1);
      for (int i = 0; i < 4; i++) wbit(1'($urandom_range(0, 1)));
      tx_data = 8'hC3;
      tx_valid = 1'b1;
      i2c_start();
      wbyte(8'hA1, ack);
      check("rs_rack", ack, 1);
      rbyte(d);
      check("rs_byte", d, 8'hC3);
      wbit(1'b1);
      i2c_stop();
      check("rs_start", n_start - s_st, 2);
      check("rs_rxv", rxq.size(), 0);
      check("rs_treq", n_treq - s_tr, 1);

      // Reset while the target is pulling SDA low in a read byte.
      tx_data = 8'h00;
      tx_valid = 1'b1;
      i2c_start();
      wbyte(8'hA1, ack);
      check("rr_ack", ack, 1);
      rbit(b);
      rbit(b);
      check("rr_pre_oe", sda_oe, 1);
      rst_n = 1'b0;
      #1;
      check("rr_oe", sda_oe, 0);
      tick(3);
      rst_n = 1'b1;
      s_st = n_start;
      s_sp = n_stop;
      s_tr = n_treq;
      rxq.delete();
      for (int i = 0; i < 6; i++) rbit(b);
      wbyte(8'hA0, ack);
      check("rr_ign", ack, 0);
      check("rr_busy", busy, 0);
      i2c_stop();
      check("rr_start", n_start - s_st, 0);
      check("rr_stop", n_stop - s_sp, 1);
      check("rr_treq", n_treq - s_tr, 0);
      check("rr_rxv", rxq.size(), 0);

      for (int t = 0; t < 20; t++) begin
         logic [6:0] a;
         own_addr = 7'($urandom_range(0, 127));
         a = ($urandom_range(0, 2) != 0) ? own_addr :
             7'($urandom_range(0, 127));
         en = ($urandom_range(0, 7) != 0);
         for (int k = 0; k < 4; k++) begin
            w_data[k] = 8'($urandom);
            t_data[k] = 8'($urandom);
            w_rdy[k] = ($urandom_range(0, 3) != 0);
            t_val[k] = ($urandom_range(0, 3) != 0);
         end
         xfer(a, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
         en = 1'b1;
         tick(4);
      end

      check("rxv_txreq", n_both, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
